// File: rtl/dmem_store_buffer_if.sv
// Write/read port between the store buffer and the data RAM.
// master = store buffer side, slave = RAM side.
interface dmem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          wvalid;
  logic          wready;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  modport master (
    output wvalid, waddr, wdata, raddr,
    input  wready, rdata
  );

  modport slave (
    input  wvalid, waddr, wdata, raddr,
    output wready, rdata
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO between the MIPS core data port and a valid/ready data RAM.
// Define DMEM_STORE_BUFFER_FORWARD_EN to forward buffered stores to loads instead of stalling.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic          memread,
  input  logic          membyteread,
  input  logic [AW-1:0] aluout,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  dmem_store_buffer_if.master mem
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          full;
  logic          enq;
  logic          pop;
  logic          hit;
  logic [DW-1:0] word;
  logic [7:0]    sel_byte;
  logic [AW-3:0] ld_waddr;
`ifdef DMEM_STORE_BUFFER_FORWARD_EN
  logic [DW-1:0] fwd_data;
`endif

  assign ld_waddr   = aluout[AW-1:2];
  assign full       = (count == CW'(DEPTH));
  assign mem.wvalid = (count != '0);
  assign mem.waddr  = mem.wvalid ? {addr_q[head], 2'b00} : '0;
  assign mem.wdata  = mem.wvalid ? data_q[head] : '0;
  assign mem.raddr  = {aluout[AW-1:2], 2'b00};
  assign pop        = mem.wvalid && mem.wready;
  assign enq        = memwrite && !stall;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit = 1'b0;
`ifdef DMEM_STORE_BUFFER_FORWARD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (addr_q[head + PW'(k)] == ld_waddr)) begin
        hit = 1'b1;
`ifdef DMEM_STORE_BUFFER_FORWARD_EN
        fwd_data = data_q[head + PW'(k)];
`endif
      end
    end
  end

`ifdef DMEM_STORE_BUFFER_FORWARD_EN
  assign stall = memwrite && full;
  assign word  = hit ? fwd_data : mem.rdata;
`else
  assign stall = (memwrite && full) || (memread && hit);
  assign word  = mem.rdata;
`endif

  always_comb begin
    sel_byte = word[7:0];
    case (aluout[1:0])
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
  end

  always_comb begin
    readdata = mem.rdata;
    if (memread) begin
      readdata = membyteread ? {{(DW-8){sel_byte[7]}}, sel_byte} : word;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards all queued stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= aluout[AW-1:2];
      data_q[tail] <= writedata;
    end
  end

endmodule
